// File: rtl/knn_mem_arbiter_if.sv
// rtl/knn_mem_arbiter_if.sv - requester/memory bus bundle for the k-NN memory arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface knn_mem_arbiter_if #(
  parameter int W         = 32,
  parameter int ADDRESS_W = 16
);
  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [ADDRESS_W-1:0] addr0;
  logic [ADDRESS_W-1:0] addr1;
  logic [W-1:0]         wdata0;
  logic [W-1:0]         wdata1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 rvalid0;
  logic                 rvalid1;
  logic [W-1:0]         rdata0;
  logic [W-1:0]         rdata1;
  logic                 read;
  logic [ADDRESS_W-1:0] readaddress;
  logic                 write;
  logic [ADDRESS_W-1:0] writeaddress;
  logic [W-1:0]         writedata;
  logic [W-1:0]         readdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, readdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           read, readaddress, write, writeaddress, writedata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, readdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           read, readaddress, write, writeaddress, writedata
  );
endinterface

// File: rtl/knn_mem_arbiter.sv
// rtl/knn_mem_arbiter.sv - two-requester burst arbiter onto one memory port with in-order read return.
// KNN_ARB_FIXED_PRIO_EN selects fixed priority for requester 0 instead of round-robin.
module knn_mem_arbiter #(
  parameter int W         = 32,
  parameter int ADDRESS_W = 16,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  knn_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);

  state_t               state_q, state_d;
  logic                 last_owner_q, last_owner_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic [7:0]           beat_next;

  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [ADDRESS_W-1:0] readaddress_q, readaddress_d;
  logic [ADDRESS_W-1:0] writeaddress_q, writeaddress_d;
  logic [W-1:0]         writedata_q, writedata_d;
  logic                 rd_owner_q, rd_owner_d;

  logic [RD_LAT-1:0]    tag_v_q, tag_v_d;
  logic [RD_LAT-1:0]    tag_o_q, tag_o_d;
  logic                 rvalid0_q, rvalid0_d;
  logic                 rvalid1_q, rvalid1_d;
  logic [W-1:0]         rdata0_q, rdata0_d;
  logic [W-1:0]         rdata1_q, rdata1_d;

  logic                 gnt0, gnt1, accept, acc_we;
  logic [ADDRESS_W-1:0] acc_addr;
  logic [W-1:0]         acc_wdata;

  assign gnt0      = (state_q == OWN0) && bus.req0;
  assign gnt1      = (state_q == OWN1) && bus.req1;
  assign accept    = gnt0 || gnt1;
  assign acc_we    = gnt0 ? bus.we0 : bus.we1;
  assign acc_addr  = gnt0 ? bus.addr0 : bus.addr1;
  assign acc_wdata = gnt0 ? bus.wdata0 : bus.wdata1;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    beat_next    = beat_cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        beat_cnt_d = 8'd0;
        if (bus.req0 && bus.req1) begin
`ifdef KNN_ARB_FIXED_PRIO_EN
          state_d = OWN0;
`else
          state_d = last_owner_q ? OWN0 : OWN1;
`endif
        end else if (bus.req0) begin
          state_d = OWN0;
        end else if (bus.req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          last_owner_d = 1'b0;
          beat_cnt_d   = 8'd0;
          state_d      = bus.req1 ? OWN1 : IDLE;
        end else if (beat_next == MAX_BURST_B) begin
          beat_cnt_d = 8'd0;
`ifndef KNN_ARB_FIXED_PRIO_EN
          if (bus.req1) begin
            last_owner_d = 1'b0;
            state_d      = OWN1;
          end
`endif
        end else begin
          beat_cnt_d = beat_next;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          last_owner_d = 1'b1;
          beat_cnt_d   = 8'd0;
          state_d      = bus.req0 ? OWN0 : IDLE;
        end else if (beat_next == MAX_BURST_B) begin
          beat_cnt_d = 8'd0;
          if (bus.req0) begin
            last_owner_d = 1'b1;
            state_d      = OWN0;
          end
        end else begin
          beat_cnt_d = beat_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command register plus a (valid, owner) shift pipeline aligned with memory latency.
  always_comb begin
    read_d         = accept && !acc_we;
    write_d        = accept && acc_we;
    readaddress_d  = (accept && !acc_we) ? acc_addr : readaddress_q;
    writeaddress_d = (accept && acc_we) ? acc_addr : writeaddress_q;
    writedata_d    = (accept && acc_we) ? acc_wdata : writedata_q;
    rd_owner_d     = gnt1;
    tag_v_d        = RD_LAT'({tag_v_q, read_q});
    tag_o_d        = RD_LAT'({tag_o_q, rd_owner_q});
    rvalid0_d      = tag_v_q[RD_LAT-1] && !tag_o_q[RD_LAT-1];
    rvalid1_d      = tag_v_q[RD_LAT-1] && tag_o_q[RD_LAT-1];
    rdata0_d       = rvalid0_d ? bus.readdata : rdata0_q;
    rdata1_d       = rvalid1_d ? bus.readdata : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_owner_q   <= 1'b1;
      beat_cnt_q     <= 8'd0;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
      readaddress_q  <= '0;
      writeaddress_q <= '0;
      writedata_q    <= '0;
      rd_owner_q     <= 1'b0;
      tag_v_q        <= '0;
      tag_o_q        <= '0;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      beat_cnt_q     <= beat_cnt_d;
      read_q         <= read_d;
      write_q        <= write_d;
      readaddress_q  <= readaddress_d;
      writeaddress_q <= writeaddress_d;
      writedata_q    <= writedata_d;
      rd_owner_q     <= rd_owner_d;
      tag_v_q        <= tag_v_d;
      tag_o_q        <= tag_o_d;
      rvalid0_q      <= rvalid0_d;
      rvalid1_q      <= rvalid1_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
    end
  end

  assign bus.gnt0         = gnt0;
  assign bus.gnt1         = gnt1;
  assign bus.read         = read_q;
  assign bus.write        = write_q;
  assign bus.readaddress  = readaddress_q;
  assign bus.writeaddress = writeaddress_q;
  assign bus.writedata    = writedata_q;
  assign bus.rvalid0      = rvalid0_q;
  assign bus.rvalid1      = rvalid1_q;
  assign bus.rdata0       = rdata0_q;
  assign bus.rdata1       = rdata1_q;

endmodule

// File: tb/tb_knn_mem_arbiter.sv
// tb/tb_knn_mem_arbiter.sv - randomized phases against an ownership/scoreboard model of the arbiter.
module tb_knn_mem_arbiter;
  localparam int W         = 32;
  localparam int AW        = 16;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 8;
  localparam int NCYC      = 4096;
`ifdef KNN_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  knn_mem_arbiter_if #(.W(W), .ADDRESS_W(AW)) bus ();

  knn_mem_arbiter #(.W(W), .ADDRESS_W(AW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            due;
    int            who;
    logic [W-1:0]  data;
  } ret_t;

  typedef struct {
    int n;
    int p0;
    int p1;
    int pwe;
    int rst_at;
  } phase_t;

  phase_t ph [13] = '{
    '{2, 0, 0, 0, -1},
    '{2, 100, 0, 0, -1},
    '{10, 0, 0, 0, -1},
    '{2, 0, 100, 100, -1},
    '{4, 0, 0, 0, -1},
    '{40, 100, 100, 50, -1},
    '{6, 100, 0, 0, -1},
    '{6, 0, 100, 0, -1},
    '{10, 0, 0, 0, -1},
    '{6, 100, 0, 0, 4},
    '{600, 50, 50, 50, -1},
    '{600, 80, 30, 30, 300},
    '{400, 20, 90, 60, -1}
  };

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int own, last, beats;
  logic          e_read, e_write;
  logic [AW-1:0] e_raddr, e_waddr;
  logic [W-1:0]  e_wdata, e_rdata0, e_rdata1;
  ret_t          retq[$];
  logic          rd_hist [NCYC];
  logic [AW-1:0] ra_hist [NCYC];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
    return {~a, a} ^ 32'h3C5A_0F96;
  endfunction

  task automatic model_reset();
    own = -1; last = 1; beats = 0;
    e_read = 1'b0; e_write = 1'b0;
    e_raddr = '0; e_waddr = '0; e_wdata = '0;
    e_rdata0 = '0; e_rdata1 = '0;
    retq.delete();
  endtask

  task automatic next_owner(input bit q0, input bit q1);
    bit qx, qo;
    if (own < 0) begin
      beats = 0;
      if (q0 && q1) own = FIXED ? 0 : ((last == 1) ? 0 : 1);
      else if (q0)  own = 0;
      else if (q1)  own = 1;
    end else begin
      qx = (own == 0) ? q0 : q1;
      qo = (own == 0) ? q1 : q0;
      if (!qx) begin
        last  = own;
        beats = 0;
        own   = qo ? 1 - own : -1;
      end else begin
        beats++;
        if (beats == MAX_BURST) begin
          beats = 0;
          if (qo && (!FIXED || own == 1)) begin
            last = own;
            own  = 1 - own;
          end
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit q0, input bit q1, input bit w0, input bit w1,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1);
    int idx;
    bit g0, g1, rv0, rv1;
    rst = r;
    bus.req0 = q0; bus.req1 = q1; bus.we0 = w0; bus.we1 = w1;
    bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
    idx = cyc - RD_LAT;
    bus.readdata = (idx >= 0 && rd_hist[idx] === 1'b1) ? mem_word(ra_hist[idx]) : W'($urandom);
    @(negedge clk);
    g0 = (own == 0) && q0;
    g1 = (own == 1) && q1;
    rv0 = 1'b0; rv1 = 1'b0;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      if (retq[0].who == 0) begin rv0 = 1'b1; e_rdata0 = retq[0].data; end
      else begin rv1 = 1'b1; e_rdata1 = retq[0].data; end
      void'(retq.pop_front());
    end
    check_eq("gnt0", bus.gnt0, g0);
    check_eq("gnt1", bus.gnt1, g1);
    check_eq("read", bus.read, e_read);
    check_eq("write", bus.write, e_write);
    check_eq("readaddress", bus.readaddress, e_raddr);
    check_eq("writeaddress", bus.writeaddress, e_waddr);
    check_eq("writedata", bus.writedata, e_wdata);
    check_eq("rvalid0", bus.rvalid0, rv0);
    check_eq("rvalid1", bus.rvalid1, rv1);
    check_eq("rdata0", bus.rdata0, e_rdata0);
    check_eq("rdata1", bus.rdata1, e_rdata1);
    rd_hist[cyc] = bus.read;
    ra_hist[cyc] = bus.readaddress;
    if (r) begin
      model_reset();
    end else begin
      e_read  = (g0 && !w0) || (g1 && !w1);
      e_write = (g0 && w0) || (g1 && w1);
      if (e_read) begin
        e_raddr = g0 ? a0 : a1;
        retq.push_back('{due: cyc + RD_LAT + 2, who: (g1 ? 1 : 0), data: mem_word(e_raddr)});
      end
      if (e_write) begin
        e_waddr = g0 ? a0 : a1;
        e_wdata = g0 ? d0 : d1;
      end
      next_owner(q0, q1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.readdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int p = 0; p < 13; p++) begin
      for (int k = 0; k < ph[p].n; k++) begin
        step(k == ph[p].rst_at,
             $urandom_range(99) < ph[p].p0,
             $urandom_range(99) < ph[p].p1,
             $urandom_range(99) < ph[p].pwe,
             $urandom_range(99) < ph[p].pwe,
             AW'($urandom), AW'($urandom), W'($urandom), W'($urandom));
      end
    end
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    check_eq("drain_empty", retq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/knn_mem_arbiter.md
KNN_MEM_ARBITER -- requirements
Module: knn_mem_arbiter

Interface
REQ-001 Parameter W, default 32, memory data width in bits.
REQ-002 Parameter ADDRESS_W, default 16, memory address width in bits.
REQ-003 Parameter RD_LAT, default 2, cycles from `read` high to `readdata` valid; legal range 1..8.
REQ-004 Parameter MAX_BURST, default 8, maximum consecutive accepted beats per ownership; legal range 1..255.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req0, req1  in  1 each  requester x requests one memory beat (0 = training/input fetch, 1 = result write-back).
REQ-008 we0, we1  in  1 each  1 = write beat, 0 = read beat.
REQ-009 addr0, addr1  in  ADDRESS_W each  beat address.
REQ-010 wdata0, wdata1  in  W each  write data.
REQ-011 gnt0, gnt1  out  1 each  beat accepted at this edge when reqx && gntx.
REQ-012 rvalid0, rvalid1  out  1 each  one-cycle read-return strobe for requester x.
REQ-013 rdata0, rdata1  out  W each  read return data, valid with rvalidx.
REQ-014 read, readaddress  out  1 / ADDRESS_W  memory read command.
REQ-015 write, writeaddress, writedata  out  1 / ADDRESS_W / W  memory write command.
REQ-016 readdata  in  W  memory read data, valid RD_LAT cycles after `read`.

Function
REQ-017 FSM states IDLE, OWN0, OWN1; gntx = (state==OWNx) && reqx, combinational; never both high.
REQ-018 IDLE: no request -> stay; exactly one reqx -> OWNx; both -> OWN of requester not equal to last_owner (round-robin).
REQ-019 IDLE -> OWNx costs one cycle; first grant earliest in cycle after the request is seen.
REQ-020 Accepted beat (reqx && gntx at edge) drives, next cycle only, read=!wex or write=wex with registered address/data; both strobes otherwise 0.
REQ-021 Beat counter (8 bits) counts accepted beats in current ownership, cleared on every ownership entry.
REQ-022 In OWNx with reqx low: other requester high -> OWN other; else -> IDLE; last_owner <= x.
REQ-023 Beat making counter reach MAX_BURST: other requester high -> switch to OWN other (no idle cycle); else stay OWNx, counter cleared.
REQ-024 Read tag pipeline, RD_LAT deep, carries (valid, owner) per issued read; fully pipelined, no read stall, no limit on outstanding reads.
REQ-025 Tag reaching the pipeline end: next cycle rvalid<owner>=1, rdata<owner>=registered readdata; total read latency from grant edge = RD_LAT+2 cycles.
REQ-026 Returns delivered in issue order; ownership change never drops or reorders in-flight returns.
REQ-027 rdatax holds its last value when rvalidx low.

Reset
REQ-028 rst high at edge: state=IDLE, last_owner=1 (requester 0 wins first tie), counter=0, tag pipeline cleared.
REQ-029 Output reset values: read=0, write=0, rvalid0=rvalid1=0, rdata0=rdata1=0, readaddress=writeaddress=0, writedata=0; gnt0=gnt1=0 while in IDLE.
REQ-030 Reset mid-operation: in-flight reads discarded, no rvalid for them after reset; pending command in output register dropped.

Configuration
REQ-031 Macro KNN_ARB_FIXED_PRIO_EN defined: requester 0 wins every IDLE tie and every MAX_BURST boundary; requester 1 loses ownership at its MAX_BURST boundary whenever req0 high; last_owner ignored.
REQ-032 Macro undefined: round-robin per REQ-018/REQ-023; ports identical in both builds.

Verification
REQ-033 req0 only, we0=0, addr0=0x0010, readdata=0xA5A5_0001 -> gnt0 cycle 2, read=1 readaddress=0x0010 cycle 3, rvalid0=1 rdata0=0xA5A5_0001 cycle 3+RD_LAT+1.
REQ-034 req0 and req1 both high from reset, held -> OWN0 for 8 beats, then OWN1 for 8 beats, alternating, no idle cycle between bursts.
REQ-035 req1 write, wdata1=0xDEAD_BEEF addr1=0x0100, single beat -> write=1, writeaddress=0x0100, writedata=0xDEAD_BEEF one cycle; read stays 0.
REQ-036 Four reads by requester 0 then switch to requester 1 reads -> rvalid0 four times, then rvalid1, order preserved, no cross-routing.
REQ-037 rst asserted one cycle after 3 reads issued -> no rvalid0/rvalid1 afterwards, all outputs at reset values next cycle.
REQ-038 KNN_ARB_FIXED_PRIO_EN, both requesting continuously -> gnt1 never asserted; drop req0 -> OWN1 within 1 cycle.
